// File: rtl/mario_motion.sv
`timescale 1ns/1ps
// Per-frame player motion: walking, jumping under gravity, ground/brick collision
// and right-edge scrolling, stepped once per synchronised rising edge of frame_clk.
module mario_motion #(
    parameter int X_START     = 100,
    parameter int Y_GROUND    = 400,
    parameter int X_MIN       = 16,
    parameter int SCROLL_EDGE = 300,
    parameter int STEP        = 2,
    parameter int JUMP_V      = 18,
    parameter int GRAV        = 1,
    parameter int VMAX        = 8,
    parameter int SIZE_X      = 12,
    parameter int SIZE_Y      = 16,
    parameter int BRICK_X0    = 230,
    parameter int BRICK_X1    = 320,
    parameter int BRICK_TOP   = 250,
    parameter int BRICK_BOT   = 280
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size_X,
    output logic [9:0] Ball_size_Y,
    output logic [5:0] logx,
    output logic       airborne,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;

    localparam logic [10:0] P_X_MIN       = 11'(X_MIN);
    localparam logic [10:0] P_SCROLL_EDGE = 11'(SCROLL_EDGE);
    localparam logic [10:0] P_STEP        = 11'(STEP);
    localparam logic [10:0] P_GRAV        = 11'(GRAV);
    localparam logic [10:0] P_VMAX        = 11'(VMAX);
    localparam logic [10:0] P_SIZE_Y      = 11'(SIZE_Y);
    localparam logic [10:0] P_Y_GROUND    = 11'(Y_GROUND);
    localparam logic [10:0] P_BRICK_X0    = 11'(BRICK_X0);
    localparam logic [10:0] P_BRICK_X1    = 11'(BRICK_X1);
    localparam logic [10:0] P_BRICK_TOP   = 11'(BRICK_TOP);
    localparam logic [10:0] P_BRICK_BOT   = 11'(BRICK_BOT);
    localparam logic [10:0] P_LOGX_MAX    = 11'd62;

    logic        fsync1, fsync2, fdly, tick;
    logic [1:0]  state, state_nxt;
    logic [5:0]  vy, vy_nxt;
    logic [9:0]  x_nxt, y_nxt;
    logic [5:0]  l_nxt;
    logic [10:0] x_ext, y_ext, v_ext, l_sum, world;
    logic [10:0] y_rise, v_fall, y_fall;
    logic        on_brick;

    assign Ball_size_X = 10'(SIZE_X);
    assign Ball_size_Y = 10'(SIZE_Y);
    assign state_dbg   = state;

    // frame_clk comes from another clock domain; two flops resync, the third finds the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fsync1 <= 1'b0;
            fsync2 <= 1'b0;
            fdly   <= 1'b0;
        end else begin
            fsync1 <= frame_clk;
            fsync2 <= fsync1;
            fdly   <= fsync2;
        end
    end

    assign tick  = fsync2 & ~fdly;
    assign x_ext = 11'(BallX);
    assign y_ext = 11'(BallY);
    assign v_ext = 11'(vy);

    always_comb begin
        x_nxt = BallX;
        l_nxt = logx;
        l_sum = 11'(logx) + P_STEP;
        if (keycode == KEY_LEFT) begin
            if (x_ext >= P_X_MIN + P_STEP) x_nxt = 10'(x_ext - P_STEP);
            else                           x_nxt = 10'(P_X_MIN);
        end else if (keycode == KEY_RIGHT) begin
            if (x_ext + P_STEP <= P_SCROLL_EDGE) x_nxt = 10'(x_ext + P_STEP);
            else if (l_sum > P_LOGX_MAX)         l_nxt = 6'(P_LOGX_MAX);
            else                                 l_nxt = 6'(l_sum);
        end
    end

    // Brick overlap is judged in world coordinates after this tick's horizontal move.
    assign world    = 11'(x_nxt) + 11'(l_nxt);
    assign on_brick = (world > P_BRICK_X0) && (world < P_BRICK_X1);

    always_comb begin
        state_nxt = state;
        vy_nxt    = vy;
        y_nxt     = BallY;
        y_rise    = y_ext - v_ext;
        v_fall    = (v_ext + P_GRAV > P_VMAX) ? P_VMAX : v_ext + P_GRAV;
        y_fall    = y_ext + v_fall;
        case (state)
            ST_GROUND: begin
                if (keycode == KEY_JUMP) begin
                    state_nxt = ST_RISE;
                    vy_nxt    = 6'(JUMP_V);
                end else if ((y_ext == P_BRICK_TOP - P_SIZE_Y) && !on_brick) begin
                    state_nxt = ST_FALL;
                    vy_nxt    = '0;
                end
            end
            ST_RISE: begin
                // Head bump: head was below the brick underside and crosses it this frame.
                if (on_brick && (y_ext >= P_BRICK_BOT + P_SIZE_Y) &&
                    (y_rise < P_BRICK_BOT + P_SIZE_Y)) begin
                    y_nxt     = 10'(P_BRICK_BOT + P_SIZE_Y);
                    vy_nxt    = '0;
                    state_nxt = ST_FALL;
                end else begin
                    y_nxt = 10'(y_rise);
                    if (v_ext <= P_GRAV) begin
                        vy_nxt    = '0;
                        state_nxt = ST_FALL;
                    end else begin
                        vy_nxt = 6'(v_ext - P_GRAV);
                    end
                end
            end
            ST_FALL: begin
                if (on_brick && (y_ext + P_SIZE_Y <= P_BRICK_TOP) &&
                    (y_fall + P_SIZE_Y >= P_BRICK_TOP)) begin
                    y_nxt     = 10'(P_BRICK_TOP - P_SIZE_Y);
                    vy_nxt    = '0;
                    state_nxt = ST_GROUND;
                end else if (y_fall + P_SIZE_Y >= P_Y_GROUND) begin
                    y_nxt     = 10'(P_Y_GROUND - P_SIZE_Y);
                    vy_nxt    = '0;
                    state_nxt = ST_GROUND;
                end else begin
                    y_nxt  = 10'(y_fall);
                    vy_nxt = 6'(v_fall);
                end
            end
            default: begin
                state_nxt = ST_GROUND;
                vy_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            BallX    <= 10'(X_START);
            BallY    <= 10'(Y_GROUND - SIZE_Y);
            logx     <= '0;
            vy       <= '0;
            state    <= ST_GROUND;
            airborne <= 1'b0;
        end else if (tick) begin
            BallX    <= x_nxt;
            BallY    <= y_nxt;
            logx     <= l_nxt;
            vy       <= vy_nxt;
            state    <= state_nxt;
            airborne <= (state_nxt != ST_GROUND);
        end
    end

endmodule
